// File: rtl/mfcc_ctrl_pkg.sv
// Shared definitions for the MFCC front-end loop sequencer:
// state encoding, default index widths and the standard frame length.
package mfcc_ctrl_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int FRM_W_DEF = 10;

  localparam logic [11:0] FRAME_LEN_DEF = 12'd400;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } loop_state_e;

endpackage

// File: rtl/frame_loop_ctrl_if.sv
// Run-control / datapath handshake bundle for frame_loop_ctrl.
// master = run control side, slave = the loop sequencer.
interface frame_loop_ctrl_if
  import mfcc_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FRM_W = FRM_W_DEF
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_frame_len;
  logic [FRM_W-1:0] cfg_num_frames;
  logic             stall;
  logic             frame_ack;

  logic             sample_valid;
  logic [CNT_W-1:0] sample_idx;
  logic [FRM_W-1:0] frame_idx;
  logic             frame_last;
  logic             frame_done;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output start, abort, cfg_frame_len, cfg_num_frames, stall, frame_ack,
    input  sample_valid, sample_idx, frame_idx, frame_last, frame_done,
           busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_frame_len, cfg_num_frames, stall, frame_ack,
    output sample_valid, sample_idx, frame_idx, frame_last, frame_done,
           busy, done, cfg_err
  );

endinterface

// File: rtl/term_cnt.sv
// Up-counter with a latched limit: load captures the limit and clears the
// count, en advances and wraps to 0 at limit-1, clr zeroes the count only.
module term_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] lim_in,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         tc_nxt
);

  logic [W-1:0] lim_q;
  logic [W-1:0] lim_nxt;
  logic [W-1:0] q_nxt;

  assign tc = (q == lim_q - W'(1));

  always_comb begin
    lim_nxt = load ? lim_in : lim_q;
    q_nxt   = q;
    if (clr || load) begin
      q_nxt = '0;
    end else if (en) begin
      q_nxt = tc ? '0 : q + W'(1);
    end
  end

  // Terminal flag for the value the counter will hold after this edge.
  assign tc_nxt = (q_nxt == lim_nxt - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      lim_q <= '0;
    end else begin
      q     <= q_nxt;
      lim_q <= lim_nxt;
    end
  end

endmodule

// File: rtl/frame_loop_ctrl.sv
// Nested sample/frame loop sequencer for the MFCC front end.
// state    | meaning
// IDLE     | waiting for start; config checked and latched here
// RUN      | issuing sample strobes, frozen while stall is high
// WAIT_ACK | frame issued, holding until downstream frame_ack
// DONE     | one-cycle completion pulse, then back to IDLE
module frame_loop_ctrl
  import mfcc_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FRM_W = FRM_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  frame_loop_ctrl_if.slave  bus
);

  loop_state_e      state_q, state_d;
  logic             cfg_zero, start_ok;
  logic             s_en, f_en;
  logic             s_tc, s_tc_nxt, f_tc, f_tc_nxt;
  logic [CNT_W-1:0] s_q;
  logic [FRM_W-1:0] f_q;

  logic valid_d, last_d, fdone_d, done_d, busy_d, err_d;
  logic valid_q, last_q, fdone_q, done_q, busy_q, err_q;
  logic unused_ok;

  assign cfg_zero = (bus.cfg_frame_len == '0) || (bus.cfg_num_frames == '0);
  assign start_ok = (state_q == IDLE) && bus.start && !bus.abort && !cfg_zero;

  // Sample counter advances once per strobe actually issued.
  assign s_en = (state_q == RUN) && valid_q;
  assign f_en = (state_q == WAIT_ACK) && bus.frame_ack && !f_tc;

  term_cnt #(.W(CNT_W)) u_sample_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_ok),
    .lim_in (bus.cfg_frame_len),
    .clr    (bus.abort),
    .en     (s_en),
    .q      (s_q),
    .tc     (s_tc),
    .tc_nxt (s_tc_nxt)
  );

  term_cnt #(.W(FRM_W)) u_frame_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_ok),
    .lim_in (bus.cfg_num_frames),
    .clr    (bus.abort),
    .en     (f_en),
    .q      (f_q),
    .tc     (f_tc),
    .tc_nxt (f_tc_nxt)
  );

  assign unused_ok = ^{s_tc, f_tc_nxt};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = RUN;
      RUN:      if (valid_q && last_q) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.frame_ack) state_d = f_tc ? DONE : RUN;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;

    // Output values for the next cycle, decided from the next state.
    valid_d = (state_d == RUN) && !bus.stall;
    last_d  = valid_d && s_tc_nxt;
    fdone_d = (state_d == WAIT_ACK) && (state_q != WAIT_ACK);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    err_d   = (state_q == IDLE) && bus.start && !bus.abort && cfg_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fdone_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fdone_q <= fdone_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.sample_valid = valid_q;
  assign bus.sample_idx   = s_q;
  assign bus.frame_idx    = f_q;
  assign bus.frame_last   = last_q;
  assign bus.frame_done   = fdone_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = err_q;

endmodule

// File: doc/frame_loop_ctrl.md
Name: frame_loop_ctrl

Overview:
- Sequencer that walks the MFCC front end through nested sample/frame loops.
- Inner loop: sample index 0..frame_len-1. Outer loop: frame index 0..num_frames-1.
- Issues one sample strobe per non-stalled cycle to the windowing/FFT datapath, then holds at each frame boundary until the downstream stage acknowledges frame completion.
- Sits between the top-level run control and the per-frame datapath counters. Owns all loop bookkeeping for one utterance.

Parameters:
- CNT_W, 12, width of sample index and frame_len config.
- FRM_W, 10, width of frame index and num_frames config.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- cfg_frame_len  in  CNT_W  samples per frame; latched on accepted start.
- cfg_num_frames  in  FRM_W  frames per run; latched on accepted start.
- stall  in  1  downstream not ready; freezes sample issue.
- frame_ack  in  1  downstream finished the current frame.
- sample_valid  out  1  sample_idx/frame_idx are valid this cycle.
- sample_idx  out  CNT_W  current sample index within the frame.
- frame_idx  out  FRM_W  current frame index.
- frame_last  out  1  qualifies the last sample of a frame (asserted with sample_valid).
- frame_done  out  1  one-cycle pulse on entry to WAIT_ACK.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected for zero config.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including indices and the latched config.
- All outputs are registered. There are no combinational paths from input to output.
- States: IDLE, RUN, WAIT_ACK, DONE.
- IDLE:
  - On start with both cfg values nonzero: latch cfg, clear indices, go to RUN. busy=1 next cycle.
  - On start with either cfg value equal to 0: cfg_err=1 for one cycle, stay in IDLE, latched cfg unchanged.
- RUN:
  - Latency: start sampled at edge N gives the first sample_valid in the cycle after edge N (sample_idx=0, frame_idx=0).
  - Each cycle with stall=0: sample_valid=1 and sample_idx advances by 1 on the next edge.
  - With stall=1: sample_valid=0 and the indices hold.
  - When the sample_idx about to issue equals frame_len-1: frame_last=1 together with sample_valid. Next state is WAIT_ACK. sample_idx wraps to 0.
- WAIT_ACK:
  - frame_done pulses in the first cycle. sample_valid=0.
  - On frame_ack: if frame_idx == num_frames-1, go to DONE. Otherwise frame_idx+1 and go to RUN.
  - frame_ack is sampled only in WAIT_ACK and ignored in all other states.
  - frame_ack asserted in the same cycle as the frame_done pulse is accepted.
- DONE: done=1 for one cycle, then IDLE. Indices stay at their final values until the next accepted start.
- start outside IDLE is ignored and has no side effects.
- abort:
  - Takes priority over every other input, including a simultaneous start or frame_ack.
  - Next state is IDLE. sample_valid, frame_last, frame_done and done are forced to 0. Indices are cleared.
  - No done pulse is generated.
- frame_len=1: every issued sample has frame_last=1.
- Full-scale config (frame_len = 2^CNT_W-1, num_frames = 2^FRM_W-1) completes without index overflow.
- Index comparisons use the latched config only. Changing cfg_* mid-run has no effect.
- Asynchronous reset mid-run returns to the reset state immediately. No pulses are emitted.

Decomposition:
- Shared package mfcc_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, WAIT_ACK=2'd2, DONE=2'd3);
  - default CNT_W and FRM_W;
  - the standard frame length constant FRAME_LEN_DEF=12'd400.
- One natural sub-module: term_cnt, a loadable enable/clear counter with a terminal-count flag and wrap-to-0.
  - Instantiated twice: once for samples, once for frames.
- The FSM and output registers live in frame_loop_ctrl.

Test Plan:
- Basic run: frame_len=4, num_frames=2, no stall. Expect 4 sample_valid per frame (frame_last on sample_idx=3), a frame_done pulse per frame, frame_ack 2 cycles later each time, then done exactly once, busy falling with the return to IDLE.
- Stall: frame_len=5, stall high for 3 cycles at sample_idx=2. Expect sample_idx to hold at 2 with sample_valid=0 during the stall, then indices 2,3,4 issue. The total is exactly 5 valid strobes.
- Zero config: start with cfg_frame_len=0, num_frames=3. Expect cfg_err for one cycle, busy=0 and no sample_valid. Repeat with num_frames=0.
- Abort: abort asserted at frame_idx=1, sample_idx=7 of a frame_len=16, num_frames=4 run. Expect IDLE on the next cycle with all indices 0, no done pulse, and a following start running normally.
- Edge config: frame_len=1, num_frames=3, with frame_ack held high continuously. Expect frame_last on every valid and a frame_done per frame. The sequence is RUN→WAIT_ACK→RUN with ack accepted in the first WAIT_ACK cycle. Expect done after the 3rd frame.
- Ignored inputs: start pulsed during RUN, and frame_ack pulsed during RUN, have no effect. Run completes with the originally latched cfg after cfg_* inputs change mid-run.
